// File: rtl/seg7_pkg.sv
// -----------------------------------------------------------------------------
// seg7_pkg
// Shared types and constants for the seven-segment scan controller.
//   scan_state_t : scan FSM states (BLANK = all digits off, SHOW = one digit lit)
//   SEG_0..SEG_9 : segment patterns {a,b,c,d,e,f,g}, active-high
//   SEG_OFF      : all segments dark (used for invalid BCD and blanking)
// -----------------------------------------------------------------------------
package seg7_pkg;

    typedef enum logic [0:0] {
        BLANK = 1'b0,
        SHOW  = 1'b1
    } scan_state_t;

    // Patterns are {a,b,c,d,e,f,g}; the decimal point is appended by the top.
    localparam logic [6:0] SEG_0   = 7'h7E;
    localparam logic [6:0] SEG_1   = 7'h30;
    localparam logic [6:0] SEG_2   = 7'h6D;
    localparam logic [6:0] SEG_3   = 7'h79;
    localparam logic [6:0] SEG_4   = 7'h33;
    localparam logic [6:0] SEG_5   = 7'h5B;
    localparam logic [6:0] SEG_6   = 7'h5F;
    localparam logic [6:0] SEG_7   = 7'h70;
    localparam logic [6:0] SEG_8   = 7'h7F;
    localparam logic [6:0] SEG_9   = 7'h7B;
    localparam logic [6:0] SEG_OFF = 7'h00;

    // True when a BCD nibble holds the value zero (leading-zero detection).
    function automatic logic bcd_is_zero(input logic [3:0] nib);
        return (nib == 4'd0);
    endfunction

endpackage

// File: rtl/seg7_decode.sv
// -----------------------------------------------------------------------------
// seg7_decode
// Combinational BCD to seven-segment decoder. Codes 10..15 decode to dark.
//   bcd  in  4  BCD digit value
//   seg7 out 7  {a,b,c,d,e,f,g}, active-high
// -----------------------------------------------------------------------------
module seg7_decode
    import seg7_pkg::*;
(
    input  logic [3:0] bcd,
    output logic [6:0] seg7
);

    // Table lookup of the segment pattern for one digit.
    always_comb begin
        seg7 = SEG_OFF;
        case (bcd)
            4'd0:    seg7 = SEG_0;
            4'd1:    seg7 = SEG_1;
            4'd2:    seg7 = SEG_2;
            4'd3:    seg7 = SEG_3;
            4'd4:    seg7 = SEG_4;
            4'd5:    seg7 = SEG_5;
            4'd6:    seg7 = SEG_6;
            4'd7:    seg7 = SEG_7;
            4'd8:    seg7 = SEG_8;
            4'd9:    seg7 = SEG_9;
            default: seg7 = SEG_OFF;
        endcase
    end

endmodule

// File: rtl/seg7_scan_ctrl.sv
// -----------------------------------------------------------------------------
// seg7_scan_ctrl
// Time-multiplexed scan controller for a NUM_DIGITS seven-segment display.
// Each digit is preceded by a blanking gap; new data is taken over a
// valid/ready handshake into a pending slot and committed to the display
// registers only at a frame boundary, so a frame never shows mixed data.
//   clk        in   1             system clock
//   rst_n      in   1             synchronous active-low reset
//   bcd_in     in   4*NUM_DIGITS  digit i at [4i+3:4i]
//   dp_in      in   NUM_DIGITS    decimal point per digit, 1 = lit
//   lz_blank   in   1             1 = suppress leading zeros (live level)
//   load_valid in   1             bcd_in/dp_in valid
//   load_ready out  1             1 = pending slot empty
//   seg        out  8             {a,b,c,d,e,f,g,dp}, registered
//   dig_en     out  NUM_DIGITS    one-hot digit enable, registered
//   frame_done out  1             pulse at end of the last digit's lit period
// -----------------------------------------------------------------------------
module seg7_scan_ctrl
    import seg7_pkg::*;
#(
    parameter int NUM_DIGITS   = 4,
    parameter int TICK_DIV     = 12500,
    parameter int BLANK_CYCLES = 250
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [4*NUM_DIGITS-1:0]   bcd_in,
    input  logic [NUM_DIGITS-1:0]     dp_in,
    input  logic                      lz_blank,
    input  logic                      load_valid,
    output logic                      load_ready,
    output logic [7:0]                seg,
    output logic [NUM_DIGITS-1:0]     dig_en,
    output logic                      frame_done
);

    localparam int IDX_W   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    // The blanking count runs 1..BLANK_CYCLES so that the first gap after
    // reset is one cycle longer (the reset cycle itself is not counted);
    // the counter therefore has to hold BLANK_CYCLES as well as TICK_DIV-1.
    localparam int CNT_SPAN = (TICK_DIV > BLANK_CYCLES + 1) ? TICK_DIV : BLANK_CYCLES + 1;
    localparam int CNT_W    = (CNT_SPAN > 2) ? $clog2(CNT_SPAN) : 1;

    localparam logic [CNT_W-1:0] CNT_ZERO   = CNT_W'(0);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
    localparam logic [CNT_W-1:0] TICK_LAST  = CNT_W'(TICK_DIV - 1);
    localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES);
    localparam logic [IDX_W-1:0] IDX_ZERO   = IDX_W'(0);
    localparam logic [IDX_W-1:0] IDX_ONE    = IDX_W'(1);
    localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(NUM_DIGITS - 1);

    scan_state_t               state_r, state_s;
    logic [CNT_W-1:0]          cnt_r, cnt_s;
    logic [IDX_W-1:0]          idx_r, idx_s;
    logic                      frame_end_s;

    logic [4*NUM_DIGITS-1:0]   pend_bcd_r, disp_bcd_r;
    logic [NUM_DIGITS-1:0]     pend_dp_r, disp_dp_r;
    logic                      load_ready_r;
    logic                      commit_s, accept_s;

    logic [NUM_DIGITS-1:0]     lz_mask_s;
    logic [3:0]                cur_bcd_s;
    logic                      cur_dp_s, cur_lz_s;
    logic [6:0]                seg7_dec_s;
    logic [NUM_DIGITS-1:0]     dig_onehot_s;
    logic [7:0]                seg_next_s;
    logic [NUM_DIGITS-1:0]     dig_en_next_s;

    logic [7:0]                seg_r;
    logic [NUM_DIGITS-1:0]     dig_en_r;
    logic                      frame_done_r;

    // Scan FSM: blank gap, then one digit lit, advancing the digit index.
    always_comb begin
        state_s     = state_r;
        cnt_s       = cnt_r + CNT_ONE;
        idx_s       = idx_r;
        frame_end_s = 1'b0;
        case (state_r)
            BLANK: begin
                if (cnt_r == BLANK_LAST) begin
                    state_s = SHOW;
                    cnt_s   = CNT_ZERO;
                end else begin
                    cnt_s   = cnt_r + CNT_ONE;
                end
            end
            SHOW: begin
                if (cnt_r == TICK_LAST) begin
                    state_s = BLANK;
                    // Entering BLANK on this edge already counts as its first cycle.
                    cnt_s   = CNT_ONE;
                    if (idx_r == IDX_LAST) begin
                        idx_s       = IDX_ZERO;
                        frame_end_s = 1'b1;
                    end else begin
                        idx_s       = idx_r + IDX_ONE;
                    end
                end else begin
                    cnt_s   = cnt_r + CNT_ONE;
                end
            end
            default: begin
                state_s = BLANK;
                cnt_s   = CNT_ZERO;
                idx_s   = IDX_ZERO;
            end
        endcase
    end

    // Handshake: commit only at frame end; accept only while the slot is empty.
    always_comb begin
        commit_s = frame_end_s & ~load_ready_r;
        accept_s = load_valid & load_ready_r;
    end

    // Leading-zero mask: a digit is suppressible when it and every digit above are zero.
    always_comb begin
        logic zero_run;
        zero_run  = 1'b1;
        lz_mask_s = '0;
        for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
            zero_run     = zero_run & bcd_is_zero(disp_bcd_r[4*i +: 4]);
            lz_mask_s[i] = zero_run;
        end
    end

    // Select the data of the digit that will be lit after this edge.
    always_comb begin
        cur_bcd_s    = 4'd0;
        cur_dp_s     = 1'b0;
        cur_lz_s     = 1'b0;
        dig_onehot_s = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (idx_s == IDX_W'(i)) begin
                cur_bcd_s       = disp_bcd_r[4*i +: 4];
                cur_dp_s        = disp_dp_r[i];
                cur_lz_s        = lz_mask_s[i];
                dig_onehot_s[i] = 1'b1;
            end else begin
                dig_onehot_s[i] = 1'b0;
            end
        end
    end

    seg7_decode u_decode (
        .bcd  (cur_bcd_s),
        .seg7 (seg7_dec_s)
    );

    // Next output values, all dark whenever the FSM is heading into BLANK.
    always_comb begin
        seg_next_s    = 8'h00;
        dig_en_next_s = '0;
        if (state_s == SHOW) begin
            dig_en_next_s = dig_onehot_s;
            seg_next_s    = {(lz_blank && cur_lz_s) ? SEG_OFF : seg7_dec_s, cur_dp_s};
        end else begin
            dig_en_next_s = '0;
            seg_next_s    = 8'h00;
        end
    end

    // Scan state, counters and registered display outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r      <= BLANK;
            cnt_r        <= CNT_ZERO;
            idx_r        <= IDX_ZERO;
            seg_r        <= 8'h00;
            dig_en_r     <= '0;
            frame_done_r <= 1'b0;
        end else begin
            state_r      <= state_s;
            cnt_r        <= cnt_s;
            idx_r        <= idx_s;
            seg_r        <= seg_next_s;
            dig_en_r     <= dig_en_next_s;
            frame_done_r <= frame_end_s;
        end
    end

    // Pending slot and display registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pend_bcd_r   <= '0;
            pend_dp_r    <= '0;
            disp_bcd_r   <= '0;
            disp_dp_r    <= '0;
            load_ready_r <= 1'b1;
        end else if (commit_s) begin
            disp_bcd_r   <= pend_bcd_r;
            disp_dp_r    <= pend_dp_r;
            load_ready_r <= 1'b1;
        end else if (accept_s) begin
            pend_bcd_r   <= bcd_in;
            pend_dp_r    <= dp_in;
            load_ready_r <= 1'b0;
        end else begin
            load_ready_r <= load_ready_r;
        end
    end

    assign seg        = seg_r;
    assign dig_en     = dig_en_r;
    assign frame_done = frame_done_r;
    assign load_ready = load_ready_r;

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// -----------------------------------------------------------------------------
// tb_seg7_scan_ctrl
// Self-checking bench for seg7_scan_ctrl (NUM_DIGITS=4, TICK_DIV=8,
// BLANK_CYCLES=2). The reference model derives the expected outputs from the
// number of clock edges since reset release using plain arithmetic.
// -----------------------------------------------------------------------------
module tb_seg7_scan_ctrl;

    localparam int N     = 4;
    localparam int TICK  = 8;
    localparam int BLNK  = 2;
    localparam int PER   = TICK + BLNK;
    localparam int FRAME = N * PER;

    logic             clk;
    logic             rst_n;
    logic [4*N-1:0]   bcd_in;
    logic [N-1:0]     dp_in;
    logic             lz_blank;
    logic             load_valid;
    logic             load_ready;
    logic [7:0]       seg;
    logic [N-1:0]     dig_en;
    logic             frame_done;

    int checks = 0;
    int errors = 0;

    // Reference model state
    int             k;
    logic [15:0]    m_disp, m_pend;
    logic [3:0]     m_dpd, m_dpp;
    bit             m_full;
    logic [13:0]    exp_v;
    logic [7:0]     tbl [10] = '{8'hFC, 8'h60, 8'hDA, 8'hF2, 8'h66,
                                 8'hB6, 8'hBE, 8'hE0, 8'hFE, 8'hF6};

    seg7_scan_ctrl #(
        .NUM_DIGITS   (N),
        .TICK_DIV     (TICK),
        .BLANK_CYCLES (BLNK)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .bcd_in     (bcd_in),
        .dp_in      (dp_in),
        .lz_blank   (lz_blank),
        .load_valid (load_valid),
        .load_ready (load_ready),
        .seg        (seg),
        .dig_en     (dig_en),
        .frame_done (frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One clock edge; the model is advanced with the inputs seen at that edge.
    task automatic tick();
        int u, d;
        bit fd, full_pre, supp;
        logic [3:0] v;
        logic [7:0] e_seg;
        logic [3:0] e_dig;
        @(posedge clk);
        if (!rst_n) begin
            k = 0; m_disp = '0; m_dpd = '0; m_pend = '0; m_dpp = '0; m_full = 0;
            exp_v = {8'h00, 4'b0000, 1'b0, 1'b1};
        end else begin
            k++;
            u = k - BLNK - 1;
            fd = (u >= 0) && ((u % FRAME) == FRAME - BLNK);
            full_pre = m_full;
            if (fd && full_pre) begin
                m_disp = m_pend; m_dpd = m_dpp; m_full = 0;
            end else if (load_valid && !full_pre) begin
                m_pend = bcd_in; m_dpp = dp_in; m_full = 1;
            end
            e_seg = 8'h00; e_dig = 4'b0000;
            if (u >= 0 && (u % PER) < TICK) begin
                d = (u / PER) % N;
                v = m_disp[4*d +: 4];
                supp = lz_blank && (d != 0) && ((m_disp >> (4*d)) == 16'h0000);
                e_seg = ((v <= 4'd9) && !supp) ? tbl[v] : 8'h00;
                e_seg[0] = m_dpd[d];
                e_dig = 4'b0001 << d;
            end
            exp_v = {e_seg, e_dig, fd, !m_full};
        end
        #1;
    endtask

    task automatic do_load(input logic [15:0] b, input logic [3:0] dp);
        bcd_in = b; dp_in = dp; load_valid = 1'b1;
        tick();
        load_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; load_valid = 1'b0; lz_blank = 1'b0; bcd_in = '0; dp_in = '0;
        for (int c = 0; c < 3; c++) begin
            tick();
            checks++;
            if ({seg, dig_en, frame_done, load_ready} !== exp_v) begin
                errors++;
                $display("FAIL reset cyc %0d got %h expected %h", c, {seg, dig_en, frame_done, load_ready}, exp_v);
            end
        end
        rst_n = 1'b1;
        for (int c = 1; c <= 3; c++) begin
            tick();
            checks++;
            if ({seg, dig_en, frame_done, load_ready} !== exp_v) begin
                errors++;
                $display("FAIL reset_release edge %0d got %h expected %h", c, {seg, dig_en, frame_done, load_ready}, exp_v);
            end
        end
        checks++;
        if (dig_en !== 4'b0001) begin
            errors++;
            $display("FAIL first_lit_edge3 dig_en got %b expected 0001", dig_en);
        end
    endtask

    task automatic test_load_scan();
        int fd_cnt = 0;
        do_load(16'h1234, 4'b0000);
        for (int c = 0; c < 2 * FRAME; c++) begin
            tick();
            if (frame_done) fd_cnt++;
            checks++;
            if ({seg, dig_en, frame_done, load_ready} !== exp_v) begin
                errors++;
                $display("FAIL scan_1234 cyc %0d got %h expected %h", c, {seg, dig_en, frame_done, load_ready}, exp_v);
            end
        end
        checks++;
        if (fd_cnt != 2) begin
            errors++;
            $display("FAIL frame_done_count got %0d expected 2", fd_cnt);
        end
    endtask

    task automatic test_midframe();
        for (int c = 0; c < 15; c++) tick();
        do_load(16'h5678, 4'b0000);
        checks++;
        if (load_ready !== 1'b0) begin
            errors++;
            $display("FAIL ready_after_load got %b expected 0", load_ready);
        end
        do_load(16'h9999, 4'b1111);
        for (int c = 0; c < 2 * FRAME + 10; c++) begin
            tick();
            checks++;
            if ({seg, dig_en, frame_done, load_ready} !== exp_v) begin
                errors++;
                $display("FAIL midframe cyc %0d got %h expected %h", c, {seg, dig_en, frame_done, load_ready}, exp_v);
            end
        end
    endtask

    task automatic test_lz_blank();
        lz_blank = 1'b1;
        do_load(16'h0070, 4'b0000);
        for (int c = 0; c < 2 * FRAME + 10; c++) begin
            tick();
            checks++;
            if ({seg, dig_en, frame_done, load_ready} !== exp_v) begin
                errors++;
                $display("FAIL lz_0070 cyc %0d got %h expected %h", c, {seg, dig_en, frame_done, load_ready}, exp_v);
            end
        end
        do_load(16'h0000, 4'b0000);
        for (int c = 0; c < 2 * FRAME + 10; c++) begin
            tick();
            checks++;
            if ({seg, dig_en, frame_done, load_ready} !== exp_v) begin
                errors++;
                $display("FAIL lz_0000 cyc %0d got %h expected %h", c, {seg, dig_en, frame_done, load_ready}, exp_v);
            end
        end
        lz_blank = 1'b0;
    endtask

    task automatic test_dp_invalid();
        do_load(16'h00A0, 4'b0010);
        for (int c = 0; c < 2 * FRAME + 10; c++) begin
            tick();
            checks++;
            if ({seg, dig_en, frame_done, load_ready} !== exp_v) begin
                errors++;
                $display("FAIL dp_00A0 cyc %0d got %h expected %h", c, {seg, dig_en, frame_done, load_ready}, exp_v);
            end
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 10 * FRAME; c++) begin
            bcd_in     = 16'($urandom);
            dp_in      = 4'($urandom);
            load_valid = ($urandom_range(0, 7) == 0);
            if ($urandom_range(0, 49) == 0) lz_blank = ~lz_blank;
            tick();
            checks++;
            if ({seg, dig_en, frame_done, load_ready} !== exp_v) begin
                errors++;
                $display("FAIL random cyc %0d got %h expected %h", c, {seg, dig_en, frame_done, load_ready}, exp_v);
            end
        end
        load_valid = 1'b0;
        lz_blank   = 1'b0;
    endtask

    task automatic test_reset_mid();
        int budget = 0;
        do_load(16'h4321, 4'b1111);
        while (!(exp_v[9:6] != 4'b0000 && m_full) && budget < 2 * FRAME) begin
            tick();
            budget++;
        end
        checks++;
        if (budget >= 2 * FRAME) begin
            errors++;
            $display("FAIL reset_mid_setup timeout got %0d cycles expected < %0d", budget, 2 * FRAME);
        end
        rst_n = 1'b0;
        tick();
        checks++;
        if ({seg, dig_en, frame_done, load_ready} !== {8'h00, 4'b0000, 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL reset_mid got %h expected %h", {seg, dig_en, frame_done, load_ready}, {8'h00, 4'b0000, 1'b0, 1'b1});
        end
        rst_n = 1'b1;
        for (int c = 0; c < 2 * FRAME; c++) begin
            tick();
            checks++;
            if ({seg, dig_en, frame_done, load_ready} !== exp_v) begin
                errors++;
                $display("FAIL after_reset_mid cyc %0d got %h expected %h", c, {seg, dig_en, frame_done, load_ready}, exp_v);
            end
        end
    endtask

    initial begin
        test_reset();
        test_load_scan();
        test_midframe();
        test_lz_blank();
        test_dp_invalid();
        test_random();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
